// File: rtl/multdiv_sequencer_if.sv
// rtl/multdiv_sequencer_if.sv - operand/control/result bundle for the multiply/divide sequencer
interface multdiv_sequencer_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - fixed 32-iteration signed shift-add multiply / restoring divide
module multdiv_sequencer (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q;
    logic [4:0]  count_q;
    logic        op_div_q;
    logic        sign_q;
    logic        divzero_q;
    logic [31:0] a_mag_q;
    logic [31:0] b_mag_q;
    logic [31:0] acc_hi_q;
    logic [31:0] acc_lo_q;
    logic [31:0] result_q;
    logic        exception_q;
    logic        rdy_q;
    logic        busy_q;

    logic        start;
    logic [31:0] a_mag_d, b_mag_d;
    logic [32:0] mult_sum;
    logic [32:0] rem_sh, trial;
    logic [31:0] quot_sh;
    logic [31:0] acc_hi_d, acc_lo_d;
    logic [63:0] prod, prod_s;
    logic [31:0] quot_s;
    logic [31:0] result_d;
    logic        exception_d;

    always_comb begin
        start   = bus.ctrl_MULT | bus.ctrl_DIV;
        a_mag_d = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
        b_mag_d = bus.data_operandB[31] ? (~bus.data_operandB + 32'd1) : bus.data_operandB;

        // Multiply: carry out of the add becomes the new MSB after the right shift.
        mult_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_mag_q} : 33'd0);

        // Divide: remainder lives in acc_hi, quotient/dividend shifts through acc_lo.
        rem_sh  = {acc_hi_q, acc_lo_q[31]};
        quot_sh = {acc_lo_q[30:0], 1'b0};
        trial   = rem_sh + ~{1'b0, b_mag_q} + 33'd1;

        if (op_div_q) begin
            if (!trial[32]) begin
                acc_hi_d = trial[31:0];
                acc_lo_d = quot_sh | 32'd1;
            end else begin
                acc_hi_d = rem_sh[31:0];
                acc_lo_d = quot_sh;
            end
        end else begin
            acc_hi_d = mult_sum[32:1];
            acc_lo_d = {mult_sum[0], acc_lo_q[31:1]};
        end

        prod   = {acc_hi_q, acc_lo_q};
        prod_s = sign_q ? (~prod + 64'd1) : prod;
        quot_s = sign_q ? (~acc_lo_q + 32'd1) : acc_lo_q;

        if (!op_div_q) begin
            result_d    = prod_s[31:0];
            exception_d = (prod_s[63:32] != {32{prod_s[31]}});
        end else if (divzero_q) begin
            result_d    = 32'd0;
            exception_d = 1'b1;
        end else begin
            // Only -2^31 / -1 overflows; its wrapped result is 0x80000000 either way.
            result_d    = quot_s;
            exception_d = (acc_lo_q == 32'h8000_0000) && !sign_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 5'd0;
            op_div_q    <= 1'b0;
            sign_q      <= 1'b0;
            divzero_q   <= 1'b0;
            a_mag_q     <= 32'd0;
            b_mag_q     <= 32'd0;
            acc_hi_q    <= 32'd0;
            acc_lo_q    <= 32'd0;
            result_q    <= 32'd0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else if (start) begin
            // A start in any state (re)launches; an aborted operation never reports.
            state_q   <= RUN;
            count_q   <= 5'd0;
            op_div_q  <= !bus.ctrl_MULT;
            sign_q    <= bus.data_operandA[31] ^ bus.data_operandB[31];
            divzero_q <= !bus.ctrl_MULT && (bus.data_operandB == 32'd0);
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= bus.ctrl_MULT ? b_mag_d : a_mag_d;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    count_q  <= count_q + 5'd1;
                    if (count_q == 5'd31) state_q <= FIX;
                end
                FIX: begin
                    result_q    <= result_d;
                    exception_q <= exception_d;
                    rdy_q       <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= DONE;
                end
                DONE: begin
                    rdy_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exception_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - directed self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    multdiv_sequencer_if bus();

    multdiv_sequencer dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start edge is the posedge between the two negedges; returns at the negedge after it.
    task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clk);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int lat, output int busy_cnt);
        int  n;
        bit  seen;
        lat = -1; busy_cnt = 0; n = 0; seen = 0;
        while (!seen && n < 45) begin
            if (bus.data_resultRDY) begin
                lat  = n;
                seen = 1;
            end else begin
                if (bus.busy) busy_cnt++;
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        int lat, bc;
        pulse(m, d, a, b);
        wait_rdy(lat, bc);
        chk({tag, "_latency"}, lat, 33);
        chk({tag, "_busy_cycles"}, bc, 33);
        chk({tag, "_result"}, bus.data_result, exp_res);
        chk({tag, "_exception"}, {31'd0, bus.data_exception}, {31'd0, exp_exc});
        chk({tag, "_busy_at_rdy"}, {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_rdy_single"}, {31'd0, bus.data_resultRDY}, 32'd0);
        chk({tag, "_result_held"}, bus.data_result, exp_res);
    endtask

    initial begin
        int lat, bc, rdy_hits;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_result", bus.data_result, 32'd0);
        chk("reset_exc", {31'd0, bus.data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);

        run_op("mul_7x-3",     1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mul_ovf",      1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("mul_min_x1",   1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
        run_op("div_-7/2",     0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
        run_op("div_100/7",    0, 1, 32'd100,        32'd7,         32'd14,        1'b0);
        run_op("div_by_zero",  0, 1, 32'd100,        32'd0,         32'd0,         1'b1);
        run_op("div_min/-1",   0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("mul_div_both", 1, 1, 32'd6,          32'd3,         32'd18,        1'b0);
        run_op("mul_-5x-6",    1, 0, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 32'd30,        1'b0);

        // Abort: MULT at edge 0, DIV restart at edge 10.
        pulse(1, 0, 32'd5, 32'd6);
        repeat (8) @(negedge clk);
        pulse(0, 1, 32'd30, 32'd5);
        chk("abort_result_kept", bus.data_result, 32'd30);
        wait_rdy(lat, bc);
        chk("abort_latency", lat, 33);
        chk("abort_result", bus.data_result, 32'd6);
        chk("abort_exc", {31'd0, bus.data_exception}, 32'd0);

        // Reset mid-operation at start+20.
        pulse(1, 0, 32'd3, 32'd4);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_result", bus.data_result, 32'd0);
        chk("rst_mid_exc", {31'd0, bus.data_exception}, 32'd0);
        rdy_hits = 0;
        repeat (40) begin
            if (bus.data_resultRDY) rdy_hits++;
            @(negedge clk);
        end
        chk("rst_mid_no_rdy", rdy_hits, 0);
        chk("rst_mid_result_later", bus.data_result, 32'd0);
        run_op("mul_3x4_after_rst", 1, 0, 32'd3, 32'd4, 32'd12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
